// File: rtl/comm_pkg.sv
// Shared definitions for the communications-port transmitter: FSM state
// encoding, occupancy-width helper and the default baud divisor.
package comm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   // 50 MHz system clock / 115200 baud
   localparam int COMM_DEFAULT_CLK_DIV = 434;

   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/comm_sync_fifo.sv
// Single-clock FIFO; pointers carry an extra MSB so full and empty are told
// apart without a separate counter.
module comm_sync_fifo
   import comm_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                                 clk_i,
   input  logic                                 srst_i,
   input  logic                                 push_i,
   input  logic [DATA_W-1:0]                    push_data_i,
   input  logic                                 pop_i,
   output logic [DATA_W-1:0]                    pop_data_o,
   output logic                                 full_o,
   output logic                                 empty_o,
   output logic [level_width(FIFO_DEPTH)-1:0]   level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = level_width(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic              push_ok;
   logic              pop_ok;

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   // Head word is captured by the consumer's shift register on pop.
   assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign level_o    = LW'(wr_ptr_q - rd_ptr_q);
   assign full_o     = (level_o == LW'(FIFO_DEPTH));
   assign empty_o    = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/comm_tx_fifo.sv
// FIFO-fed LSB-first serial transmitter with back-to-back framing.
// Define COMM_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module comm_tx_fifo
   import comm_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int CLK_DIV    = COMM_DEFAULT_CLK_DIV,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                                 sys_clk_i,
   input  logic                                 sys_rst_i,
   input  logic                                 wr_en_i,
   input  logic [DATA_W-1:0]                    wr_data_i,
   output logic                                 full_o,
   output logic [level_width(FIFO_DEPTH)-1:0]   level_o,
   output logic                                 c_tx,
   output logic                                 c_bussy
);

   localparam int LW     = level_width(FIFO_DEPTH);
   localparam int BAUD_W = $clog2(CLK_DIV);
   localparam int BIT_W  = $clog2(DATA_W);
   localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_W - 1);
   localparam logic              STOP_LAST   = 1'(STOP_BITS - 1);

   tx_state_e          state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic               stop_cnt_q, stop_cnt_d;
   logic               c_tx_q, c_tx_d;
   logic               bussy_q, bussy_d;
`ifdef COMM_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic               fifo_pop;
   logic [DATA_W-1:0]  fifo_data;
   logic               fifo_empty;
   logic               fifo_full;
   logic [LW-1:0]      fifo_level;
   logic [LW-1:0]      level_d;
   logic               push_ok;
   logic               bit_end;
   logic               start_frame;

   comm_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (sys_clk_i),
      .srst_i      (sys_rst_i),
      .push_i      (wr_en_i),
      .push_data_i (wr_data_i),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   assign push_ok = wr_en_i && !fifo_full;
   assign level_d = fifo_level + LW'(push_ok) - LW'(fifo_pop);
   assign bit_end = (baud_q == '0);

   always_comb begin
      state_d     = state_q;
      baud_d      = bit_end ? baud_q : baud_q - BAUD_W'(1);
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      start_frame = 1'b0;
      fifo_pop    = 1'b0;
`ifdef COMM_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) start_frame = 1'b1;
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               baud_d  = BAUD_RELOAD;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d  = BAUD_RELOAD;
               shift_d = shift_q >> 1;
               if (bit_cnt_q == BIT_LAST) begin
                  stop_cnt_d = 1'b0;
`ifdef COMM_TX_PARITY_EN
                  state_d    = ST_PARITY;
`else
                  state_d    = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
`ifdef COMM_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d    = ST_STOP;
               baud_d     = BAUD_RELOAD;
               stop_cnt_d = 1'b0;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (stop_cnt_q == STOP_LAST) begin
                  // A queued word starts its start bit with no idle cycle.
                  if (!fifo_empty) start_frame = 1'b1;
                  else             state_d     = ST_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
                  baud_d     = BAUD_RELOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_frame) begin
         fifo_pop  = 1'b1;
         shift_d   = fifo_data;
         bit_cnt_d = '0;
         state_d   = ST_START;
         baud_d    = BAUD_RELOAD;
`ifdef COMM_TX_PARITY_EN
         parity_d  = ^fifo_data;
`endif
      end

      // Line level is registered from the next state so it moves with the FSM.
      case (state_d)
         ST_START:  c_tx_d = 1'b0;
         ST_DATA:   c_tx_d = shift_d[0];
`ifdef COMM_TX_PARITY_EN
         ST_PARITY: c_tx_d = parity_d;
`endif
         default:   c_tx_d = 1'b1;
      endcase

      bussy_d = (state_d != ST_IDLE) || (level_d != '0);
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         c_tx_q     <= 1'b1;
         bussy_q    <= 1'b0;
`ifdef COMM_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         c_tx_q     <= c_tx_d;
         bussy_q    <= bussy_d;
`ifdef COMM_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign c_tx    = c_tx_q;
   assign c_bussy = bussy_q;
   assign full_o  = fifo_full;
   assign level_o = fifo_level;

endmodule

// File: tb/tb_comm_tx_fifo.sv
// Scoreboard bench for comm_tx_fifo: a queue-level transmitter model predicts
// frame words and start cycles; a line monitor decodes c_tx and checks them.
module tb_comm_tx_fifo;

   localparam int DW    = 8;
   localparam int DIV   = 4;
   localparam int DEPTH = 16;
   localparam int STOPS = 1;
`ifdef COMM_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int NBITS = 1 + DW + PBITS + STOPS;
   localparam int FRAME = NBITS * DIV;

   typedef struct {
      logic [DW-1:0] w;
      int            start;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          full_o;
   logic [4:0]    level_o;
   logic          c_tx;
   logic          c_bussy;

   int            cyc = 0;
   int            mk = 0;
   int            frame_end = 0;
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] mq[$];
   exp_t          exp_q[$];

   logic          samp [64];
   int            nsamp = 0;
   bit            in_frame = 1'b0;
   int            fstart = 0;

   comm_tx_fifo #(
      .DATA_W     (DW),
      .CLK_DIV    (DIV),
      .FIFO_DEPTH (DEPTH),
      .STOP_BITS  (STOPS)
   ) dut (
      .sys_clk_i (clk),
      .sys_rst_i (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_data),
      .full_o    (full_o),
      .level_o   (level_o),
      .c_tx      (c_tx),
      .c_bussy   (c_bussy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line level expected in bit slot b of a frame carrying word w.
   function automatic logic frame_bit(input logic [DW-1:0] w, input int b);
      if (b == 0)               return 1'b0;
      if (b <= DW)              return w[b-1];
      if (PBITS == 1 && b == DW + 1) return ^w;
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, mk, act, exp);
      end
   endtask

   // One clock edge: drive inputs, advance the model at the edge, check at negedge.
   task automatic step(input bit wr, input logic [DW-1:0] d, input bit r);
      bit   full_pre;
      exp_t e;
      wr_en   = wr;
      wr_data = d;
      rst     = r;
      @(posedge clk);
      mk++;
      if (r) begin
         mq.delete();
         frame_end = 0;
      end else begin
         full_pre = (mq.size() == DEPTH);
         if (mk >= frame_end && mq.size() > 0) begin
            e.w     = mq.pop_front();
            e.start = mk;
            exp_q.push_back(e);
            frame_end = mk + FRAME;
         end
         if (wr && !full_pre) mq.push_back(d);
      end
      @(negedge clk);
      chk("level", 32'(level_o), 32'(mq.size()));
      chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
      chk("bussy", 32'(c_bussy), 32'((mk < frame_end) || (mq.size() != 0)));
      if (mk >= frame_end) chk("idle_tx", 32'(c_tx), 32'(1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   // Line monitor: collects one frame of samples and scores it against the queue.
   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      logic [DW-1:0] got;
      if (rst) begin
         in_frame = 1'b0;
         nsamp    = 0;
         exp_q.delete();
      end else if (!in_frame) begin
         if (c_tx === 1'b0) begin
            in_frame = 1'b1;
            fstart   = cyc;
            samp[0]  = c_tx;
            nsamp    = 1;
         end
      end else begin
         samp[nsamp] = c_tx;
         nsamp++;
         if (nsamp == FRAME) begin
            in_frame = 1'b0;
            got = '0;
            for (int i = 0; i < DW; i++) got[i] = samp[(1 + i) * DIV + DIV / 2];
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_frame start=%0d got=%0h expected=none", fstart, got);
            end else begin
               e  = exp_q.pop_front();
               ok = (fstart == e.start);
               for (int s = 0; s < FRAME; s++)
                  if (samp[s] !== frame_bit(e.w, s / DIV)) ok = 1'b0;
               if (ok)
                  $display("frame word=%0h start=%0d ok", got, fstart);
               else begin
                  errors++;
                  $display("FAIL frame got word=%0h start=%0d expected word=%0h start=%0d",
                           got, fstart, e.w, e.start);
               end
            end
         end
      end
   end

   initial begin
      // Reset held three cycles.
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      idle(3);

      // Single frames, including the parity-sensitive words.
      step(1'b1, 8'hA5, 1'b0);
      idle(FRAME + 5);
      step(1'b1, 8'h07, 1'b0);
      idle(FRAME + 3);
      step(1'b1, 8'h03, 1'b0);
      idle(FRAME + 3);

      // Back-to-back pair.
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      idle(2 * FRAME + 5);

      // Overflow: more pushes than the FIFO can hold while one frame is on the line.
      for (int i = 0; i < DEPTH + 2; i++) step(1'b1, DW'($urandom), 1'b0);
      idle((DEPTH + 1) * FRAME + 10);

      // Reset during the third data bit with two words still queued.
      for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
      idle(11);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      idle(2 * FRAME);

      // Randomised traffic with occasional bursts.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0)
            for (int j = 0; j < 5; j++) step(1'b1, DW'($urandom), 1'b0);
         else
            step($urandom_range(0, 7) == 0, DW'($urandom), 1'b0);
      end

      // Drain, bounded.
      for (int i = 0; i < 40 * FRAME && (mq.size() != 0 || mk < frame_end); i++) idle(1);
      idle(4);
      chk("drain", 32'(exp_q.size()) + 32'(in_frame), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
